// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage pipelined floating-point multiplier with valid/ready handshake
module fp_mul_pipe #(
    parameter  int EXP_W = 4,
    parameter  int MAN_W = 3,
    parameter  int BIAS  = 2**(EXP_W-1)-1,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] ina,
    input  logic [W-1:0] inb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [2:0]   flags
);

    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;

    localparam logic signed [EW2-1:0] BIAS_V = EW2'(BIAS);
    localparam logic signed [EW2-1:0] MAX_E  = EW2'(2**EXP_W - 1);
    localparam logic signed [EW2-1:0] ONE_E  = EW2'(1);

    // Stage valid bits
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

    // Stage 1 payload: sign, zero operand, biased exponent sum, raw significand product
    logic                  s1_sign_q, s1_sign_d;
    logic                  s1_zero_q, s1_zero_d;
    logic signed [EW2-1:0] s1_esum_q, s1_esum_d;
    logic [PW-1:0]         s1_prod_q, s1_prod_d;

    // Stage 2 payload: normalised and rounded exponent/mantissa
    logic                  s2_sign_q, s2_sign_d;
    logic                  s2_zero_q, s2_zero_d;
    logic signed [EW2-1:0] s2_esum_q, s2_esum_d;
    logic [MAN_W-1:0]      s2_man_q, s2_man_d;

    // Stage 3 payload: the packed result word and its flags
    logic [W-1:0]          out_q, out_d;
    logic [2:0]            flags_q, flags_d;

    // A single advance enable keeps every stage in lockstep; a stall freezes the whole pipe
    logic en;
    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;
    assign out       = out_q;
    assign flags     = flags_q;

    // Stage 1: split operands, sum exponents, multiply significands with hidden ones
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [PW-1:0]    op_a, op_b;
    always_comb begin
        exp_a     = ina[W-2 -: EXP_W];
        exp_b     = inb[W-2 -: EXP_W];
        op_a      = {{(PW-MAN_W-1){1'b0}}, 1'b1, ina[MAN_W-1:0]};
        op_b      = {{(PW-MAN_W-1){1'b0}}, 1'b1, inb[MAN_W-1:0]};
        v1_d      = v1_q;
        s1_sign_d = s1_sign_q;
        s1_zero_d = s1_zero_q;
        s1_esum_d = s1_esum_q;
        s1_prod_d = s1_prod_q;
        if (en) begin
            v1_d      = in_valid;
            s1_sign_d = ina[W-1] ^ inb[W-1];
            s1_zero_d = (exp_a == '0) || (exp_b == '0);
            s1_esum_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_V;
            s1_prod_d = op_a * op_b;
        end
    end

    // Stage 2: normalise the product to 1.x form, then round to nearest even
    logic [PW-2:0]         norm;
    logic signed [EW2-1:0] esum_n;
    logic [MAN_W-1:0]      man_t;
    logic                  guard, sticky, round_inc;
    logic [MAN_W:0]        man_sum;
    always_comb begin
        norm      = s1_prod_q[PW-1] ? s1_prod_q[PW-2:0] : {s1_prod_q[PW-3:0], 1'b0};
        esum_n    = s1_esum_q + {{(EW2-1){1'b0}}, s1_prod_q[PW-1]};
        man_t     = norm[PW-2 -: MAN_W];
        guard     = norm[MAN_W];
        sticky    = |norm[MAN_W-1:0];
        round_inc = guard && (sticky || man_t[0]);
        man_sum   = {1'b0, man_t} + {{MAN_W{1'b0}}, round_inc};
        v2_d      = v2_q;
        s2_sign_d = s2_sign_q;
        s2_zero_d = s2_zero_q;
        s2_esum_d = s2_esum_q;
        s2_man_d  = s2_man_q;
        if (en) begin
            v2_d      = v1_q;
            s2_sign_d = s1_sign_q;
            s2_zero_d = s1_zero_q;
            if (man_sum[MAN_W]) begin
                // Rounding carried past the top mantissa bit: 1.111.. + ulp = 10.000..
                s2_man_d  = '0;
                s2_esum_d = esum_n + ONE_E;
            end else begin
                s2_man_d  = man_sum[MAN_W-1:0];
                s2_esum_d = esum_n;
            end
        end
    end

    // Stage 3: range check and pack; zero operands win over overflow/underflow
    always_comb begin
        v3_d    = v3_q;
        out_d   = out_q;
        flags_d = flags_q;
        if (en) begin
            v3_d = v2_q;
            if (s2_zero_q) begin
                out_d   = {s2_sign_q, {(W-1){1'b0}}};
                flags_d = 3'b001;
            end else if (s2_esum_q > MAX_E) begin
                out_d   = {s2_sign_q, {(W-1){1'b1}}};
                flags_d = 3'b100;
            end else if (s2_esum_q < ONE_E) begin
                out_d   = {s2_sign_q, {(W-1){1'b0}}};
                flags_d = 3'b011;
            end else begin
                out_d   = {s2_sign_q, s2_esum_q[EXP_W-1:0], s2_man_q};
                flags_d = 3'b000;
            end
        end
    end

    // Pipeline registers; reset empties the pipe and clears the visible result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_esum_q <= '0;
            s1_prod_q <= '0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_esum_q <= '0;
            s2_man_q  <= '0;
            out_q     <= '0;
            flags_q   <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            s1_sign_q <= s1_sign_d;
            s1_zero_q <= s1_zero_d;
            s1_esum_q <= s1_esum_d;
            s1_prod_q <= s1_prod_d;
            s2_sign_q <= s2_sign_d;
            s2_zero_q <= s2_zero_d;
            s2_esum_q <= s2_esum_d;
            s2_man_q  <= s2_man_d;
            out_q     <= out_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - scoreboard bench for fp_mul_pipe in E4M3 and E5M2 configurations
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_ina, a_inb, a_out;
    logic [2:0] a_flags;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_ina, b_inb, b_out;
    logic [2:0] b_flags;

    fp_mul_pipe dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .ina(a_ina), .inb(a_inb),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out(a_out), .flags(a_flags)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .ina(b_ina), .inb(b_inb),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out(b_out), .flags(b_flags)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    bit          rand_ready = 1'b0;

    // Reference: exact integer product, rounded by remainder against half-ulp
    function automatic logic [10:0] ref_mul(input int ew, input int mw, input int bias,
                                            input logic [7:0] a, input logic [7:0] b);
        int av, bv, ea, eb, ma, mb, e, prod, sh, q, r, half, res;
        logic s;
        av = int'(a);
        bv = int'(b);
        s  = a[7] ^ b[7];
        ea = (av >> mw) & ((1 << ew) - 1);
        eb = (bv >> mw) & ((1 << ew) - 1);
        ma = (1 << mw) | (av & ((1 << mw) - 1));
        mb = (1 << mw) | (bv & ((1 << mw) - 1));
        if (ea == 0 || eb == 0) return {3'b001, s, 7'h00};
        prod = ma * mb;
        e    = ea + eb - bias;
        if (prod >= (1 << (2 * mw + 1))) begin
            e++;
            sh = mw + 1;
        end else begin
            sh = mw;
        end
        q    = prod >> sh;
        r    = prod - (q << sh);
        half = 1 << (sh - 1);
        if (r > half || (r == half && (q % 2) == 1)) q++;
        if (q == (1 << (mw + 1))) begin
            q = q >> 1;
            e++;
        end
        if (e > (1 << ew) - 1) return {3'b100, s, 7'h7F};
        if (e < 1) return {3'b011, s, 7'h00};
        res = (e << mw) | (q - (1 << mw));
        return {3'b000, s, res[6:0]};
    endfunction

    // Output monitor: scoreboard pop, stall stability and in_ready relation
    logic       a_prev_stall = 1'b0;
    logic [10:0] a_prev = '0;
    always @(negedge clk) begin
        logic [10:0] exp_v;
        n_vec++;
        if (a_in_ready !== !(a_out_valid && !a_out_ready)) begin
            n_bad++;
            $display("FAIL in_ready_a: got %b want %b", a_in_ready, !(a_out_valid && !a_out_ready));
        end
        if (a_prev_stall && a_out_valid) begin
            n_vec++;
            if ({a_flags, a_out} !== a_prev) begin
                n_bad++;
                $display("FAIL stall_hold_a: got %h want %h", {a_flags, a_out}, a_prev);
            end
        end
        a_prev_stall = a_out_valid && !a_out_ready;
        a_prev       = {a_flags, a_out};
        if (a_out_valid && a_out_ready) begin
            n_vec++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_a: got %h with empty scoreboard", {a_flags, a_out});
            end else begin
                exp_v = qa.pop_front();
                if ({a_flags, a_out} !== exp_v) begin
                    n_bad++;
                    $display("FAIL result_a: got flags=%b out=%h want flags=%b out=%h",
                             a_flags, a_out, exp_v[10:8], exp_v[7:0]);
                end
            end
        end
        if (b_out_valid && b_out_ready) begin
            n_vec++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_b: got %h with empty scoreboard", {b_flags, b_out});
            end else begin
                exp_v = qb.pop_front();
                if ({b_flags, b_out} !== exp_v) begin
                    n_bad++;
                    $display("FAIL result_b: got flags=%b out=%h want flags=%b out=%h",
                             b_flags, b_out, exp_v[10:8], exp_v[7:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        a_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Present one pair to the selected DUT and hold it until accepted; push expectation on accept
    task automatic send(input bit sel, input logic [7:0] x, input logic [7:0] y,
                        input logic [10:0] exp_v, output int waited);
        bit acc;
        acc    = 1'b0;
        waited = 0;
        if (sel) begin b_in_valid = 1'b1; b_ina = x; b_inb = y; end
        else     begin a_in_valid = 1'b1; a_ina = x; a_inb = y; end
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = sel ? b_in_ready : a_in_ready;
            if (acc) begin
                if (sel) qb.push_back(exp_v);
                else     qa.push_back(exp_v);
            end
            tick();
            waited++;
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got no in_ready within %0d cycles want acceptance", waited);
        end
    endtask

    // Send one pair with out_ready high and report edges from acceptance to out_valid
    task automatic run_single(input bit sel, input logic [7:0] x, input logic [7:0] y,
                              input logic [10:0] exp_v, output int lat);
        int  waited;
        logic ov;
        send(sel, x, y, exp_v, waited);
        lat = 1;
        forever begin
            @(negedge clk);
            ov = sel ? b_out_valid : a_out_valid;
            if (ov || lat > 20) break;
            tick();
            lat++;
        end
        tick();
    endtask

    task automatic drain(input bit sel);
        int k;
        k = 0;
        while (((sel ? qb.size() : qa.size()) != 0) && k < 300) begin
            tick();
            k++;
        end
        tick();
        n_vec++;
        if ((sel ? qb.size() : qa.size()) != 0) begin
            n_bad++;
            $display("FAIL drain_%0d: got %0d results outstanding want 0", sel,
                     sel ? qb.size() : qa.size());
        end
    endtask

    task automatic test_reset;
        int waited, lat;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({a_out_valid, a_flags, a_out} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state_a: got valid=%b flags=%b out=%h want 0", a_out_valid, a_flags, a_out);
        end
        n_vec++;
        if ({b_out_valid, b_flags, b_out} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state_b: got valid=%b flags=%b out=%h want 0", b_out_valid, b_flags, b_out);
        end
        n_vec++;
        if (a_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b0, 8'h38, 8'h38, {3'b000, 8'h38}, waited);
        n_vec++;
        if (waited != 1) begin
            n_bad++;
            $display("FAIL first_accept: got accepted after %0d edges want 1", waited);
        end
        drain(1'b0);
    endtask

    task automatic test_basic;
        logic [7:0]  ta [3] = '{8'h38, 8'h3C, 8'hB8};
        logic [7:0]  tb [3] = '{8'h38, 8'h3C, 8'h3C};
        logic [10:0] te [3] = '{11'h038, 11'h041, 11'h0BC};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_single(1'b0, ta[i], tb[i], te[i], lat);
            n_vec++;
            if (lat != 3) begin
                n_bad++;
                $display("FAIL basic_latency_%0d: got %0d want 3", i, lat);
            end
        end
    endtask

    task automatic test_rounding;
        logic [7:0]  ta [3] = '{8'h3A, 8'h39, 8'h3D};
        logic [7:0]  tb [3] = '{8'h3A, 8'h3C, 8'h39};
        logic [10:0] te [3] = '{11'h03C, 11'h03E, 11'h03F};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_single(1'b0, ta[i], tb[i], te[i], lat);
            n_vec++;
            if (lat != 3) begin
                n_bad++;
                $display("FAIL round_latency_%0d: got %0d want 3", i, lat);
            end
        end
    endtask

    task automatic test_saturation;
        logic [7:0]  ta [3] = '{8'h7F, 8'h08, 8'h85};
        logic [7:0]  tb [3] = '{8'h40, 8'h08, 8'h7F};
        logic [10:0] te [3] = '{{3'b100, 8'h7F}, {3'b011, 8'h00}, {3'b001, 8'h80}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_single(1'b0, ta[i], tb[i], te[i], lat);
            n_vec++;
            if (lat != 3) begin
                n_bad++;
                $display("FAIL sat_latency_%0d: got %0d want 3", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] x, y;
        int waited;
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            send(1'b0, x, y, ref_mul(4, 3, 7, x, y), waited);
        end
        drain(1'b0);
        rand_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight;
        int waited, lat;
        send(1'b0, 8'h3C, 8'h3C, {3'b000, 8'h41}, waited);
        send(1'b0, 8'h3A, 8'h3A, {3'b000, 8'h3C}, waited);
        rst_n = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        n_vec++;
        if ({a_out_valid, a_in_ready, a_flags, a_out} !== {1'b0, 1'b1, 11'h000}) begin
            n_bad++;
            $display("FAIL midreset_state: got valid=%b ready=%b out=%h want valid=0 ready=1 out=00",
                     a_out_valid, a_in_ready, a_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (a_out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stale_result_%0d: got out_valid=%b want 0", i, a_out_valid);
            end
            tick();
        end
        run_single(1'b0, 8'hB8, 8'h3C, {3'b000, 8'hBC}, lat);
        n_vec++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL post_reset_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_sweep;
        logic [7:0] x, y;
        int lat, waited;
        run_single(1'b1, 8'h3C, 8'h3C, {3'b000, 8'h3C}, lat);
        n_vec++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL sweep_latency: got %0d want 3", lat);
        end
        run_single(1'b1, 8'h7F, 8'h40, {3'b100, 8'h7F}, lat);
        for (int i = 0; i < 24; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            send(1'b1, x, y, ref_mul(5, 2, 15, x, y), waited);
        end
        drain(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 want finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_ina       = '0;
        a_inb       = '0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_ina       = '0;
        b_inb       = '0;
        b_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 4, sets the exponent field width; the legal range is 3..8.
REQ-002 Parameter MAN_W, default 3, sets the stored mantissa width (hidden 1 not stored); the legal range is 2..10.
REQ-003 Parameter BIAS, default 2**(EXP_W-1)-1, sets the exponent bias.
REQ-004 Derived width W = 1+EXP_W+MAN_W; word format is {sign, exp[EXP_W-1:0], man[MAN_W-1:0]}.
REQ-005 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  is the asynchronous, active-low reset.
REQ-007 in_valid  input  1  indicates that ina/inb hold an operand pair.
REQ-008 in_ready  output  1  indicates that the block accepts the pair this cycle.
REQ-009 ina, inb  input  W  are the operands.
REQ-010 out_valid  output  1  indicates that out/flags hold a result.
REQ-011 out_ready  input  1  indicates that the consumer takes the result this cycle.
REQ-012 out  output  W  is the product.
REQ-013 flags  output  3  is {ovf, unf, zero} for the result on out.

Function
REQ-014 Number format: normalised values only; no inf, NaN or subnormals; any operand with exp field 0 is treated as signed zero regardless of mantissa.
REQ-015 A transfer occurs on a rising edge with in_valid&&in_ready (input) or out_valid&&out_ready (output).
REQ-016 Three pipeline stages, each holding a valid bit and payload; global advance en = !out_valid || out_ready; in_ready = en (combinational, no dependence on in_valid).
REQ-017 When en=1, every stage loads from its predecessor (stage 1 loads in_valid); when en=0, all stages hold; out/flags stay stable while out_valid&&!out_ready.
REQ-018 Latency is 3 cycles from input transfer to out_valid with out_ready held 1; throughput is one result per cycle; bubbles propagate and are not collapsed.
REQ-019 Stage 1: sign = ina[W-1]^inb[W-1]; zero_in = either exp field 0; esum = expA+expB-BIAS at signed width EXP_W+2; P = {1,manA}*{1,manB} at width 2*MAN_W+2.
REQ-020 Stage 2, normalise: if P MSB = 1, shift by 1 and esum+1; take MAN_W mantissa bits, guard bit, and sticky = OR of the remaining bits.
REQ-021 Stage 2, rounding: round-to-nearest-even; increment when guard && (sticky || mantissa LSB); a mantissa carry-out sets the mantissa to 0 and adds esum+1.
REQ-022 Stage 3, overflow: final esum > 2**EXP_W-1 -> out = {sign, all-ones exp, all-ones man} (saturate), ovf=1.
REQ-023 Stage 3, underflow: final esum < 1 with zero_in=0 -> out = {sign, 0...0}, unf=1, zero=1.
REQ-024 Stage 3, zero input: zero_in=1 -> out = {sign, 0...0}, zero=1, ovf=unf=0, overriding any overflow or underflow.
REQ-025 Stage 3, normal case: out = {sign, esum[EXP_W-1:0], rounded man}, flags = 0.
REQ-026 Exactly one result per accepted pair, in acceptance order; no drops and no duplicates under any out_ready pattern.

Reset
REQ-027 rst_n=0 asynchronously clears all stage valid bits and sets out=0 and flags=0; out_valid=0 on assertion.
REQ-028 In-flight operands are discarded on reset, and no result for them appears after release.
REQ-029 in_ready=1 during and after reset, since out_valid=0 gives en=1.
REQ-030 The first input transfer is possible on the first rising edge after rst_n deasserts.

Verification (defaults E4M3, BIAS=7)
REQ-031 Basic products: 0x38*0x38 -> 0x38, flags 0; 0x3C*0x3C -> 0x41; 0xB8*0x3C -> 0xBC; each result appears 3 cycles after input with out_ready=1.
REQ-032 Rounding: 0x3A*0x3A (tie, even) -> 0x3C; 0x39*0x3C (tie, odd) -> 0x3E; 1.101*1.001 (0x3D*0x39, above half) -> 0x3F.
REQ-033 Saturation and flush: 0x7F*0x40 -> 0x7F, ovf=1; 0x08*0x08 -> 0x00, unf=1, zero=1; 0x85*0x7F (zero exp, nonzero mantissa) -> 0x80, zero=1, ovf=0.
REQ-034 Backpressure: stream 8 pairs back-to-back while out_ready toggles pseudo-randomly -> all 8 results arrive in order, out stable during stall, in_ready=0 exactly while out_valid&&!out_ready.
REQ-035 Reset mid-flight: accept 2 pairs, assert rst_n=0 for 1 cycle before either emerges -> out_valid=0 immediately, no stale results afterwards, the next pair yields its result 3 cycles after acceptance.
REQ-036 Parameter sweep: EXP_W=5, MAN_W=2 (BIAS 15), 1.0*1.0 (0x3C*0x3C) -> 0x3C, max*2.0 -> 0x7F with ovf=1, random products compared against a reference model.
